cache_writeback_buffer: RTL and testbench

- Other end of the way-replacement logic: when a write-enable selects a victim way, this block captures the victim line if it is valid and dirty.
- Queues captured lines in a small FIFO and drains them to L2 over a req/ack handshake.
- Forwards queued data to the read path, so a miss on a line still waiting in the buffer returns the buffered copy.
- Sits between the 2-way L1 data/tag arrays and the L2 write port.

---
 rtl/cache_writeback_buffer.sv | 148 ++++++++++++++
 tb/tb_cache_writeback_buffer.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/cache_writeback_buffer.sv
// Write-back buffer for L1 victims. Dirty lines selected for replacement are queued
// here and drained to L2. Queued copies are forwarded to read misses.
module cache_writeback_buffer #(
    parameter int idx_size   = 6,
    parameter int tag_size   = 8,
    parameter int data_width = 32,
    parameter int depth      = 4
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         evict_i,
    input  logic                         we_s1_i,
    input  logic                         we_s2_i,
    input  logic [idx_size-1:0]          idx_i,
    input  logic                         valid_s1_i,
    input  logic                         valid_s2_i,
    input  logic                         dirty_s1_i,
    input  logic                         dirty_s2_i,
    input  logic [tag_size-1:0]          tag_s1_i,
    input  logic [tag_size-1:0]          tag_s2_i,
    input  logic [data_width-1:0]        data_s1_i,
    input  logic [data_width-1:0]        data_s2_i,
    input  logic                         lookup_i,
    input  logic [tag_size+idx_size-1:0] lookup_addr_i,
    output logic                         buf_hit_o,
    output logic [data_width-1:0]        buf_data_o,
    output logic                         l2_req_o,
    output logic [tag_size+idx_size-1:0] l2_addr_o,
    output logic [data_width-1:0]        l2_data_o,
    input  logic                         l2_ack_i,
    output logic                         full_o,
    output logic                         empty_o,
    output logic                         overflow_o
);

    localparam int addr_w = tag_size + idx_size;
    localparam int ptr_w  = $clog2(depth);
    localparam int cnt_w  = $clog2(depth + 1);

    typedef enum logic [1:0] {IDLE, REQ, GAP} state_t;

    state_t                state;
    logic [addr_w-1:0]     addr_mem [depth];
    logic [data_width-1:0] data_mem [depth];
    logic [ptr_w-1:0]      head;
    logic [ptr_w-1:0]      tail;
    logic [cnt_w-1:0]      count;
    logic                  sel_s1;
    logic                  sel_s2;
    logic                  capture;
    logic                  push;
    logic                  pop;
    logic [addr_w-1:0]     cap_addr;
    logic [data_width-1:0] cap_data;

    // Exactly one way must be selected. A clean or invalid victim needs no write-back.
    assign sel_s1   = we_s1_i & ~we_s2_i;
    assign sel_s2   = we_s2_i & ~we_s1_i;
    assign capture  = evict_i & ((sel_s1 & valid_s1_i & dirty_s1_i) |
                                 (sel_s2 & valid_s2_i & dirty_s2_i));
    assign cap_addr = sel_s1 ? {tag_s1_i, idx_i} : {tag_s2_i, idx_i};
    assign cap_data = sel_s1 ? data_s1_i : data_s2_i;

    // A full FIFO still accepts a capture when the head leaves on the same edge.
    assign pop  = (state == REQ) & l2_ack_i;
    assign push = capture & ((count != cnt_w'(depth)) | pop);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            head       <= '0;
            tail       <= '0;
            count      <= '0;
            overflow_o <= 1'b0;
            for (int i = 0; i < depth; i++) begin
                addr_mem[i] <= '0;
                data_mem[i] <= '0;
            end
        end else begin
            if (push) begin
                addr_mem[tail] <= cap_addr;
                data_mem[tail] <= cap_data;
                tail           <= tail + ptr_w'(1);
            end
            if (pop) begin
                head <= head + ptr_w'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + cnt_w'(1);
                2'b01:   count <= count - cnt_w'(1);
                default: count <= count;
            endcase
            if (capture & ~push) begin
                overflow_o <= 1'b1;
            end
        end
    end

    // Drain sequencer: IDLE looks at the registered count, so every request is
    // followed by a GAP and an IDLE cycle before the next one.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state    <= IDLE;
            l2_req_o <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (count != '0) begin
                        state    <= REQ;
                        l2_req_o <= 1'b1;
                    end
                end
                REQ: begin
                    if (l2_ack_i) begin
                        state    <= GAP;
                        l2_req_o <= 1'b0;
                    end
                end
                default: begin
                    state    <= IDLE;
                    l2_req_o <= 1'b0;
                end
            endcase
        end
    end

    // The head slot is never overwritten while occupied, so these hold steady in REQ.
    assign l2_addr_o = (state == REQ) ? addr_mem[head] : '0;
    assign l2_data_o = (state == REQ) ? data_mem[head] : '0;

    // Walk oldest to newest so the last match, nearest the tail, wins.
    always_comb begin
        buf_hit_o  = 1'b0;
        buf_data_o = '0;
        if (lookup_i) begin
            for (int k = 0; k < depth; k++) begin
                if ((cnt_w'(k) < count) &&
                    (addr_mem[head + ptr_w'(k)] == lookup_addr_i)) begin
                    buf_hit_o  = 1'b1;
                    buf_data_o = data_mem[head + ptr_w'(k)];
                end
            end
        end
    end

    assign full_o  = (count == cnt_w'(depth));
    assign empty_o = (count == '0);

endmodule

// File: tb/tb_cache_writeback_buffer.sv
// Directed bench for cache_writeback_buffer; a queue holds the lines expected to
// reach L2 and is checked in order as the drain requests appear.
module tb_cache_writeback_buffer;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        evict_i, we_s1_i, we_s2_i;
    logic [5:0]  idx_i;
    logic        valid_s1_i, valid_s2_i, dirty_s1_i, dirty_s2_i;
    logic [7:0]  tag_s1_i, tag_s2_i;
    logic [31:0] data_s1_i, data_s2_i;
    logic        lookup_i;
    logic [13:0] lookup_addr_i;
    logic        buf_hit_o;
    logic [31:0] buf_data_o;
    logic        l2_req_o;
    logic [13:0] l2_addr_o;
    logic [31:0] l2_data_o;
    logic        l2_ack_i;
    logic        full_o, empty_o, overflow_o;

    typedef logic [45:0] entry_t;
    entry_t sb[$];
    int     vectors = 0;
    int     miscompares = 0;

    cache_writeback_buffer dut (
        .clk_i(clk_i), .rst_i(rst_i), .evict_i(evict_i),
        .we_s1_i(we_s1_i), .we_s2_i(we_s2_i), .idx_i(idx_i),
        .valid_s1_i(valid_s1_i), .valid_s2_i(valid_s2_i),
        .dirty_s1_i(dirty_s1_i), .dirty_s2_i(dirty_s2_i),
        .tag_s1_i(tag_s1_i), .tag_s2_i(tag_s2_i),
        .data_s1_i(data_s1_i), .data_s2_i(data_s2_i),
        .lookup_i(lookup_i), .lookup_addr_i(lookup_addr_i),
        .buf_hit_o(buf_hit_o), .buf_data_o(buf_data_o),
        .l2_req_o(l2_req_o), .l2_addr_o(l2_addr_o), .l2_data_o(l2_data_o),
        .l2_ack_i(l2_ack_i), .full_o(full_o), .empty_o(empty_o),
        .overflow_o(overflow_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_inputs();
        evict_i = 0; we_s1_i = 0; we_s2_i = 0; idx_i = '0;
        valid_s1_i = 0; valid_s2_i = 0; dirty_s1_i = 0; dirty_s2_i = 0;
        tag_s1_i = '0; tag_s2_i = '0; data_s1_i = '0; data_s2_i = '0;
    endtask

    // Drive a dirty, valid victim on one way; queue it when the bench expects acceptance.
    task automatic apply_stimulus(input logic way2, input logic [7:0] tag, input logic [5:0] ix,
                                  input logic [31:0] d, input logic accept);
        evict_i = 1; we_s1_i = ~way2; we_s2_i = way2; idx_i = ix;
        valid_s1_i = 1; valid_s2_i = 1; dirty_s1_i = 1; dirty_s2_i = 1;
        tag_s1_i = way2 ? 8'h00 : tag;  tag_s2_i = way2 ? tag : 8'h00;
        data_s1_i = way2 ? 32'h0 : d;   data_s2_i = way2 ? d : 32'h0;
        if (accept) sb.push_back({tag, ix, d});
    endtask

    // Wait for a request, compare it to the scoreboard head, ack it, then expect GAP and IDLE.
    task automatic drain_one(input string tag, input int max_wait);
        int     w;
        entry_t e;
        w = 0;
        while (!l2_req_o && w < max_wait) begin
            tick();
            w++;
        end
        check_output({tag, "_req"}, {63'b0, l2_req_o}, 64'd1);
        check_output({tag, "_sb_has_entry"}, {63'b0, sb.size() != 0}, 64'd1);
        if (l2_req_o && sb.size() != 0) begin
            e = sb.pop_front();
            check_output({tag, "_addr"}, {50'b0, l2_addr_o}, {50'b0, e[45:32]});
            check_output({tag, "_data"}, {32'b0, l2_data_o}, {32'b0, e[31:0]});
        end
        l2_ack_i = 1;
        tick();
        l2_ack_i = 0;
        check_output({tag, "_gap_req"}, {63'b0, l2_req_o}, 64'd0);
        tick();
        check_output({tag, "_idle_req"}, {63'b0, l2_req_o}, 64'd0);
    endtask

    initial begin
        entry_t e;
        rst_i = 1; l2_ack_i = 0; lookup_i = 0; lookup_addr_i = '0;
        clear_inputs();
        repeat (3) tick();
        check_output("rst_req", {63'b0, l2_req_o}, 64'd0);
        check_output("rst_addr", {50'b0, l2_addr_o}, 64'd0);
        check_output("rst_data", {32'b0, l2_data_o}, 64'd0);
        check_output("rst_empty", {63'b0, empty_o}, 64'd1);
        check_output("rst_full", {63'b0, full_o}, 64'd0);
        check_output("rst_ovf", {63'b0, overflow_o}, 64'd0);
        check_output("rst_hit", {63'b0, buf_hit_o}, 64'd0);
        rst_i = 0;
        tick();

        // Single line, latency of two edges, stable while unacked.
        apply_stimulus(1'b0, 8'hA5, 6'h03, 32'hDEADBEEF, 1'b1);
        tick();
        clear_inputs();
        check_output("t1_req_early", {63'b0, l2_req_o}, 64'd0);
        check_output("t1_not_empty", {63'b0, empty_o}, 64'd0);
        tick();
        check_output("t1_req", {63'b0, l2_req_o}, 64'd1);
        check_output("t1_addr_const", {50'b0, l2_addr_o}, 64'h2943);
        for (int i = 0; i < 5; i++) begin
            tick();
            check_output("t1_hold_req", {63'b0, l2_req_o}, 64'd1);
            check_output("t1_hold_addr", {50'b0, l2_addr_o}, 64'h2943);
            check_output("t1_hold_data", {32'b0, l2_data_o}, 64'hDEADBEEF);
        end
        drain_one("t1", 2);
        check_output("t1_empty", {63'b0, empty_o}, 64'd1);

        // Clean victim and ambiguous way selection are not captured.
        evict_i = 1; we_s2_i = 1; valid_s2_i = 1; dirty_s2_i = 0; tag_s2_i = 8'h11;
        tick();
        we_s1_i = 1; valid_s1_i = 1; dirty_s1_i = 1; dirty_s2_i = 1;
        tick();
        clear_inputs();
        for (int i = 0; i < 3; i++) begin
            tick();
            check_output("t2_empty", {63'b0, empty_o}, 64'd1);
            check_output("t2_req", {63'b0, l2_req_o}, 64'd0);
        end
        check_output("t2_ovf", {63'b0, overflow_o}, 64'd0);

        // Fill the FIFO, then capture and ack on the same edge.
        for (int i = 0; i < 4; i++) begin
            apply_stimulus(i[0], 8'h10 + 8'(i), 6'(i + 8), 32'hC000_0000 + 32'(i), 1'b1);
            tick();
        end
        clear_inputs();
        check_output("t3_full", {63'b0, full_o}, 64'd1);
        check_output("t3_req", {63'b0, l2_req_o}, 64'd1);
        e = sb[0];
        check_output("t3_head_addr", {50'b0, l2_addr_o}, {50'b0, e[45:32]});
        apply_stimulus(1'b1, 8'h77, 6'h2A, 32'h5555_AAAA, 1'b1);
        l2_ack_i = 1;
        tick();
        void'(sb.pop_front());
        l2_ack_i = 0;
        clear_inputs();
        check_output("t4_full_kept", {63'b0, full_o}, 64'd1);
        check_output("t4_ovf", {63'b0, overflow_o}, 64'd0);
        check_output("t4_gap_req", {63'b0, l2_req_o}, 64'd0);

        // Fifth capture into a full FIFO with no pop is dropped.
        apply_stimulus(1'b0, 8'hEE, 6'h3F, 32'hBAD0_BAD0, 1'b0);
        tick();
        clear_inputs();
        check_output("t5_ovf", {63'b0, overflow_o}, 64'd1);
        check_output("t5_full", {63'b0, full_o}, 64'd1);
        for (int i = 0; i < 4; i++) drain_one("t5_drain", 3);
        check_output("t5_empty", {63'b0, empty_o}, 64'd1);
        check_output("t5_ovf_sticky", {63'b0, overflow_o}, 64'd1);

        // Forwarding: newest of two matching entries wins.
        apply_stimulus(1'b0, 8'h3C, 6'h15, 32'h1, 1'b1);
        tick();
        lookup_i = 1; lookup_addr_i = {8'h3C, 6'h15};
        #1;
        check_output("t6_hit_one", {63'b0, buf_hit_o}, 64'd1);
        check_output("t6_data_one", {32'b0, buf_data_o}, 64'h1);
        apply_stimulus(1'b1, 8'h3C, 6'h15, 32'h2, 1'b1);
        tick();
        clear_inputs();
        check_output("t6_hit", {63'b0, buf_hit_o}, 64'd1);
        check_output("t6_data_newest", {32'b0, buf_data_o}, 64'h2);
        lookup_addr_i = {8'h3C, 6'h16};
        #1;
        check_output("t6_miss_hit", {63'b0, buf_hit_o}, 64'd0);
        check_output("t6_miss_data", {32'b0, buf_data_o}, 64'h0);
        lookup_i = 0; lookup_addr_i = {8'h3C, 6'h15};
        #1;
        check_output("t6_nolookup_hit", {63'b0, buf_hit_o}, 64'd0);
        check_output("t6_nolookup_data", {32'b0, buf_data_o}, 64'h0);
        drain_one("t6_drain", 3);
        drain_one("t6_drain", 3);

        // Reset in the middle of a request with three entries queued.
        for (int i = 0; i < 3; i++) begin
            apply_stimulus(1'b0, 8'h40 + 8'(i), 6'(i), 32'h7000_0000 + 32'(i), 1'b1);
            tick();
        end
        clear_inputs();
        check_output("t7_req", {63'b0, l2_req_o}, 64'd1);
        rst_i = 1;
        #1;
        sb.delete();
        check_output("t7_rst_req", {63'b0, l2_req_o}, 64'd0);
        check_output("t7_rst_empty", {63'b0, empty_o}, 64'd1);
        check_output("t7_rst_addr", {50'b0, l2_addr_o}, 64'd0);
        check_output("t7_rst_ovf", {63'b0, overflow_o}, 64'd0);
        tick();
        rst_i = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            check_output("t7_post_req", {63'b0, l2_req_o}, 64'd0);
        end
        check_output("t7_post_empty", {63'b0, empty_o}, 64'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
